dma_priority_arbiter: RTL and testbench

Channel priority and acknowledge stage of the 4-channel DMA controller. It consumes the bus-side DREQ and HLDA signals and the mask/command settings from the register datapath. It resolves fixed or rotating priority, raises a hold-request to timing-and-control, and drives DACK onto the bus interface. It also reports the active channel to the datapath and to timing-and-control.

---
 rtl/dma_priority_arbiter_pkg.sv | 20 ++
 rtl/dma_priority_arbiter_if.sv | 30 +++
 rtl/dma_priority_resolver.sv | 33 +++
 rtl/dma_priority_arbiter.sv | 142 ++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared constants and state encoding for the DMA channel priority/acknowledge stage.
package dma_priority_arbiter_pkg;

    localparam int CHANNELS = 4;
    localparam int CH_IDX_W = $clog2(CHANNELS);

    // Bit positions of the arbitration-related fields in the command register
    localparam int CMD_DISABLE   = 2;
    localparam int CMD_ROTATE    = 4;
    localparam int CMD_DREQ_LOW  = 6;
    localparam int CMD_DACK_HIGH = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GRANTED = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Bus-side and datapath-side signals of the DMA priority arbiter.
interface dma_priority_arbiter_if #(
    parameter int CHANNELS = dma_priority_arbiter_pkg::CHANNELS,
    parameter int CH_IDX_W = dma_priority_arbiter_pkg::CH_IDX_W
);
    logic [CHANNELS-1:0] DREQ;
    logic                HLDA;
    logic [CHANNELS-1:0] maskBits;
    logic                controllerDisable;
    logic                rotatePriority;
    logic                dreqSenseLow;
    logic                dackSenseHigh;
    logic                serviceDone;
    logic                hrqRequest;
    logic [CHANNELS-1:0] DACK;
    logic                grantValid;
    logic [CH_IDX_W-1:0] grantChannel;

    modport master (
        output DREQ, HLDA, maskBits, controllerDisable, rotatePriority,
               dreqSenseLow, dackSenseHigh, serviceDone,
        input  hrqRequest, DACK, grantValid, grantChannel
    );

    modport slave (
        input  DREQ, HLDA, maskBits, controllerDisable, rotatePriority,
               dreqSenseLow, dackSenseHigh, serviceDone,
        output hrqRequest, DACK, grantValid, grantChannel
    );
endinterface

// File: rtl/dma_priority_resolver.sv
// Wrap-around priority search: the channel named by i_priority_ptr is highest priority.
module dma_priority_resolver #(
    parameter int CHANNELS = dma_priority_arbiter_pkg::CHANNELS,
    parameter int CH_IDX_W = dma_priority_arbiter_pkg::CH_IDX_W
) (
    input  logic [CHANNELS-1:0] i_req_eff,
    input  logic [CH_IDX_W-1:0] i_priority_ptr,
    output logic [CH_IDX_W-1:0] o_winner_idx,
    output logic                o_any_req
);
    logic [CH_IDX_W:0]   w_sum;
    logic [CH_IDX_W-1:0] w_idx;

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        w_sum        = '0;
        w_idx        = '0;
        o_winner_idx = i_priority_ptr;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_priority_ptr} + (CH_IDX_W + 1)'(i);
            if (w_sum >= (CH_IDX_W + 1)'(CHANNELS)) begin
                w_idx = CH_IDX_W'(w_sum - (CH_IDX_W + 1)'(CHANNELS));
            end else begin
                w_idx = CH_IDX_W'(w_sum);
            end
            if (i_req_eff[w_idx]) begin
                o_winner_idx = w_idx;
            end
        end
        o_any_req = |i_req_eff;
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority resolution, hold-request and DACK generation.
// Define DMA_DREQ_SYNC_EN to pass DREQ through a 2-flop synchronizer first.
module dma_priority_arbiter #(
    parameter int CHANNELS = dma_priority_arbiter_pkg::CHANNELS,
    parameter int CH_IDX_W = dma_priority_arbiter_pkg::CH_IDX_W
) (
    input  logic                  CLK,
    input  logic                  RESET,
    dma_priority_arbiter_if.slave bus
);
    import dma_priority_arbiter_pkg::*;

    arb_state_t          r_state, w_state_nxt;
    logic [CH_IDX_W-1:0] r_priority_ptr, w_ptr_nxt;
    logic [CH_IDX_W-1:0] r_grant_channel, w_grant_nxt;
    logic [CHANNELS-1:0] r_dack_onehot, w_dack_nxt;
    logic                r_hrq_request, w_hrq_nxt;

    logic [CHANNELS-1:0] w_dreq;
    logic [CHANNELS-1:0] w_req_eff;
    logic [CHANNELS-1:0] w_winner_onehot;
    logic [CH_IDX_W-1:0] w_ptr_eff;
    logic [CH_IDX_W-1:0] w_winner_idx;
    logic [CH_IDX_W-1:0] w_ptr_inc;
    logic                w_any_req;
    logic                w_pending;

`ifdef DMA_DREQ_SYNC_EN
    logic [CHANNELS-1:0] r_dreq_meta, r_dreq_sync;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dreq_meta <= '0;
            r_dreq_sync <= '0;
        end else begin
            r_dreq_meta <= bus.DREQ;
            r_dreq_sync <= r_dreq_meta;
        end
    end

    assign w_dreq = r_dreq_sync;
`else
    assign w_dreq = bus.DREQ;
`endif

    assign w_req_eff = (bus.dreqSenseLow ? ~w_dreq : w_dreq) & ~bus.maskBits;
    assign w_ptr_eff = bus.rotatePriority ? r_priority_ptr : '0;

    dma_priority_resolver #(
        .CHANNELS (CHANNELS),
        .CH_IDX_W (CH_IDX_W)
    ) u_resolver (
        .i_req_eff      (w_req_eff),
        .i_priority_ptr (w_ptr_eff),
        .o_winner_idx   (w_winner_idx),
        .o_any_req      (w_any_req)
    );

    assign w_pending       = w_any_req & ~bus.controllerDisable;
    assign w_winner_onehot = CHANNELS'(1) << w_winner_idx;
    assign w_ptr_inc       = (r_grant_channel == CH_IDX_W'(CHANNELS - 1)) ?
                             '0 : r_grant_channel + CH_IDX_W'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_priority_ptr  <= '0;
            r_grant_channel <= '0;
            r_dack_onehot   <= '0;
            r_hrq_request   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_priority_ptr  <= w_ptr_nxt;
            r_grant_channel <= w_grant_nxt;
            r_dack_onehot   <= w_dack_nxt;
            r_hrq_request   <= w_hrq_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_priority_ptr;
        w_grant_nxt = r_grant_channel;
        w_dack_nxt  = r_dack_onehot;
        w_hrq_nxt   = r_hrq_request;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_state_nxt = REQUEST;
                    w_grant_nxt = w_winner_idx;
                    w_hrq_nxt   = 1'b1;
                end
            end
            REQUEST: begin
                if (!w_pending) begin
                    w_state_nxt = IDLE;
                    w_hrq_nxt   = 1'b0;
                end else begin
                    w_grant_nxt = w_winner_idx;
                    if (bus.HLDA) begin
                        w_state_nxt = GRANTED;
                        w_dack_nxt  = w_winner_onehot;
                    end
                end
            end
            GRANTED: begin
                // Completion wins over a simultaneous HLDA drop, but then skips RELEASE
                if (bus.serviceDone) begin
                    w_state_nxt = bus.HLDA ? RELEASE : IDLE;
                    w_dack_nxt  = '0;
                    w_hrq_nxt   = 1'b0;
                    if (bus.rotatePriority) begin
                        w_ptr_nxt = w_ptr_inc;
                    end
                end else if (!bus.HLDA) begin
                    w_state_nxt = IDLE;
                    w_dack_nxt  = '0;
                    w_hrq_nxt   = 1'b0;
                end
            end
            RELEASE: begin
                if (!bus.HLDA) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_dack_nxt  = '0;
                w_hrq_nxt   = 1'b0;
            end
        endcase
        if (!bus.rotatePriority && (r_state != GRANTED)) begin
            w_ptr_nxt = '0;
        end
    end

    assign bus.hrqRequest   = r_hrq_request;
    assign bus.DACK         = bus.dackSenseHigh ? r_dack_onehot : ~r_dack_onehot;
    assign bus.grantValid   = (r_state == GRANTED);
    assign bus.grantChannel = r_grant_channel;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter; expected grant order is queued and popped on each grant.
module tb_dma_priority_arbiter;
    import dma_priority_arbiter_pkg::*;

    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_priority_arbiter_if #(.CHANNELS(CH), .CH_IDX_W(2)) bus();

    dma_priority_arbiter #(.CHANNELS(CH), .CH_IDX_W(2)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic [CH-1:0] mon_act;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] dack_pins(input int ch);
        logic [CH-1:0] oh;
        oh = '0;
        if (ch >= 0 && ch < CH) oh[ch] = 1'b1;
        return bus.dackSenseHigh ? oh : ~oh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hrq(input string tag);
        int n;
        n = 0;
        while (!bus.hrqRequest && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_hrq_seen"}, 32'(bus.hrqRequest), 32'd1);
    endtask

    // One full request/grant/service/release cycle against the next queued channel
    task automatic grant_cycle(input bit drop_req, input int hlda_delay);
        int exp;
        int exp_ptr;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        wait_hrq("gc");
        check("req_winner", 32'(bus.grantChannel), exp);
        repeat (hlda_delay) tick();
        bus.HLDA = 1'b1;
        tick();
        check("grant_valid", 32'(bus.grantValid), 32'd1);
        check("grant_ch", 32'(bus.grantChannel), exp);
        check("grant_dack", 32'(bus.DACK), 32'(dack_pins(exp)));
        if (drop_req && exp >= 0 && exp < CH) bus.DREQ[exp] = 1'b0;
        repeat (3) tick();
        check("grant_hold_ch", 32'(bus.grantChannel), exp);
        check("grant_hold_dack", 32'(bus.DACK), 32'(dack_pins(exp)));
        bus.serviceDone = 1'b1;
        tick();
        bus.serviceDone = 1'b0;
        exp_ptr = bus.rotatePriority ? (exp + 1) % CH : 0;
        check("done_valid", 32'(bus.grantValid), 32'd0);
        check("done_hrq", 32'(bus.hrqRequest), 32'd0);
        check("done_dack", 32'(bus.DACK), 32'(dack_pins(-1)));
        check("done_state", 32'(dut.r_state), 32'(RELEASE));
        check("done_ptr", 32'(dut.r_priority_ptr), exp_ptr);
        tick();
        check("release_hold", 32'(dut.r_state), 32'(RELEASE));
        bus.HLDA = 1'b0;
        tick();
        check("release_idle", 32'(dut.r_state), 32'(IDLE));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_act = bus.dackSenseHigh ? bus.DACK : ~bus.DACK;
            check("dack_onehot0", 32'($onehot0(mon_act)), 32'd1);
            if (mon_act != '0) check("dack_in_granted", 32'(dut.r_state), 32'(GRANTED));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst                   = 1'b1;
        bus.DREQ              = '0;
        bus.HLDA              = 1'b0;
        bus.maskBits          = '0;
        bus.controllerDisable = 1'b0;
        bus.rotatePriority    = 1'b0;
        bus.dreqSenseLow      = 1'b0;
        bus.dackSenseHigh     = 1'b1;
        bus.serviceDone       = 1'b0;
        repeat (2) tick();
        check("rst_hrq", 32'(bus.hrqRequest), 32'd0);
        check("rst_dack", 32'(bus.DACK), 32'(dack_pins(-1)));
        check("rst_valid", 32'(bus.grantValid), 32'd0);
        check("rst_ch", 32'(bus.grantChannel), 32'd0);
        rst = 1'b0;
        tick();

        // Fixed priority: ch0 then ch2, each channel drops DREQ once acknowledged
        bus.DREQ = 4'b0101;
        exp_q.push_back(0);
        exp_q.push_back(2);
        grant_cycle(1'b1, 2);
        grant_cycle(1'b1, 2);

        // Rotating priority with all channels requesting
        bus.rotatePriority = 1'b1;
        bus.DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) exp_q.push_back(i % CH);
        for (int i = 0; i < 5; i++) grant_cycle(1'b0, 1);
        bus.DREQ = 4'b0000;
        bus.rotatePriority = 1'b0;
        tick();
        check("mode_switch_ptr", 32'(dut.r_priority_ptr), 32'd0);

        // Masking and controller disable
        bus.maskBits = 4'b0001;
        bus.DREQ = 4'b0001;
        tick();
        check("mask_hrq0", 32'(bus.hrqRequest), 32'd0);
        tick();
        check("mask_hrq1", 32'(bus.hrqRequest), 32'd0);
        bus.maskBits = 4'b0000;
        tick();
        check("unmask_hrq", 32'(bus.hrqRequest), 32'd1);
        check("unmask_ch", 32'(bus.grantChannel), 32'd0);
        bus.DREQ = 4'b0000;
        tick();
        check("withdraw_hrq", 32'(bus.hrqRequest), 32'd0);
        check("withdraw_state", 32'(dut.r_state), 32'(IDLE));
        bus.controllerDisable = 1'b1;
        bus.DREQ = 4'b0100;
        tick();
        check("disable_hrq", 32'(bus.hrqRequest), 32'd0);
        bus.controllerDisable = 1'b0;
        tick();
        check("enable_hrq", 32'(bus.hrqRequest), 32'd1);
        check("enable_ch", 32'(bus.grantChannel), 32'd2);
        bus.DREQ = 4'b0000;
        tick();

        // Inverted polarities; completion coinciding with HLDA drop
        bus.DREQ = 4'b1111;
        bus.dreqSenseLow = 1'b1;
        bus.dackSenseHigh = 1'b0;
        tick();
        check("pol_idle_dack", 32'(bus.DACK), 32'h0000000f);
        check("pol_idle_hrq", 32'(bus.hrqRequest), 32'd0);
        bus.DREQ = 4'b1011;
        tick();
        check("pol_hrq", 32'(bus.hrqRequest), 32'd1);
        check("pol_req_ch", 32'(bus.grantChannel), 32'd2);
        bus.HLDA = 1'b1;
        tick();
        check("pol_dack", 32'(bus.DACK), 32'h0000000b);
        check("pol_grant_ch", 32'(bus.grantChannel), 32'd2);
        bus.serviceDone = 1'b1;
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b1111;
        tick();
        bus.serviceDone = 1'b0;
        check("pol_done_state", 32'(dut.r_state), 32'(IDLE));
        check("pol_done_dack", 32'(bus.DACK), 32'h0000000f);
        check("pol_done_ptr", 32'(dut.r_priority_ptr), 32'd0);
        bus.DREQ = 4'b0000;
        bus.dreqSenseLow = 1'b0;
        bus.dackSenseHigh = 1'b1;
        tick();

        // Rotating: grant frozen against input changes, then HLDA abort
        bus.rotatePriority = 1'b1;
        bus.DREQ = 4'b0010;
        tick();
        check("abort_req_ch", 32'(bus.grantChannel), 32'd1);
        bus.HLDA = 1'b1;
        tick();
        check("abort_grant_dack", 32'(bus.DACK), 32'h00000002);
        bus.maskBits = 4'b0010;
        bus.DREQ = 4'b0001;
        bus.controllerDisable = 1'b1;
        tick();
        check("frozen_dack", 32'(bus.DACK), 32'h00000002);
        check("frozen_ch", 32'(bus.grantChannel), 32'd1);
        bus.maskBits = 4'b0000;
        bus.DREQ = 4'b0010;
        bus.controllerDisable = 1'b0;
        bus.HLDA = 1'b0;
        tick();
        check("abort_dack", 32'(bus.DACK), 32'h00000000);
        check("abort_state", 32'(dut.r_state), 32'(IDLE));
        check("abort_ptr", 32'(dut.r_priority_ptr), 32'd0);
        tick();
        check("regrant_hrq", 32'(bus.hrqRequest), 32'd1);
        bus.HLDA = 1'b1;
        tick();
        check("regrant_ch", 32'(bus.grantChannel), 32'd1);
        bus.serviceDone = 1'b1;
        bus.HLDA = 1'b0;
        tick();
        bus.serviceDone = 1'b0;
        check("done_hlda_low_state", 32'(dut.r_state), 32'(IDLE));
        check("done_hlda_low_ptr", 32'(dut.r_priority_ptr), 32'd2);

        // Asynchronous reset while granted
        bus.DREQ = 4'b1000;
        tick();
        check("pre_rst_ch", 32'(bus.grantChannel), 32'd3);
        bus.HLDA = 1'b1;
        tick();
        check("pre_rst_dack", 32'(bus.DACK), 32'h00000008);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hrq", 32'(bus.hrqRequest), 32'd0);
        check("async_rst_dack", 32'(bus.DACK), 32'h00000000);
        check("async_rst_valid", 32'(bus.grantValid), 32'd0);
        check("async_rst_ptr", 32'(dut.r_priority_ptr), 32'd0);
        check("async_rst_state", 32'(dut.r_state), 32'(IDLE));
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_hrq", 32'(bus.hrqRequest), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
